fp16_adder: RTL and testbench

- Registered IEEE-754 binary16 (half-precision) adder: out = a + b, both signed operands.
- 1 sign, 5-bit exponent (bias 15), 10-bit fraction.
- Used as the floating-point add unit of the lab datapath. Upstream logic converts decimal/real operands to binary16 before presenting them.

---
 rtl/fp16_pkg.sv | 40 ++++
 rtl/fp16_lzc.sv | 17 +
 rtl/fp16_adder.sv | 137 +++++++++++++
 tb/tb_fp16_adder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Purpose: shared binary16 format constants, operand struct and operand classifier.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;
  // First exponent that no longer encodes a finite number.
  localparam int EXP_MAX = 2 * BIAS + 1;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;

  // Subnormals (exp==0, frac!=0) are reported as zero: inputs are flushed.
  function automatic fp_class_t classify(input fp16_t x);
    if (x.exp == '0) begin
      return FP_ZERO;
    end else if (x.exp == '1) begin
      return (x.frac != '0) ? FP_NAN : FP_INF;
    end else begin
      return FP_NORMAL;
    end
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Purpose: 14-bit leading-zero counter for post-subtraction normalisation.
// Latency: combinational. Backpressure: n/a.
// Ports: data[13:0] in, count[3:0] out (14 when data is all zero).
module fp16_lzc (
  input  logic [13:0] data,
  output logic [3:0]  count
);

  // Ascending scan: the highest set bit is the last one to write count.
  always_comb begin
    count = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (data[i]) count = 4'(13 - i);
    end
  end

endmodule

// File: rtl/fp16_adder.sv
// Purpose: registered binary16 adder, out = a + b, RNE rounding, FTZ in and out.
// Latency: 1 cycle (result registered on the edge that samples a/b/in_valid).
// Backpressure: none; out holds its last value while in_valid is low.
// Ports: clk, rst_n (async active-low), in_valid, a[15:0], b[15:0] ->
//        out_valid, out[15:0].
module fp16_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] out
);

  fp16_t     fa, fb, lg, sm;
  fp_class_t ca, cb;

  assign fa = a;
  assign fb = b;
  assign ca = classify(fa);
  assign cb = classify(fb);

  // Larger magnitude becomes L; its sign is the result sign.
  logic a_ge_b;
  assign a_ge_b = {fa.exp, fa.frac} >= {fb.exp, fb.frac};
  assign lg     = a_ge_b ? fa : fb;
  assign sm     = a_ge_b ? fb : fa;

  logic [10:0] m_l, m_s;
  logic [4:0]  diff;
  assign m_l  = {1'b1, lg.frac};
  assign m_s  = {1'b1, sm.frac};
  assign diff = lg.exp - sm.exp;

  // Small significand widened with guard/round positions, then aligned.
  // Everything shifted past the round bit collapses into sticky.
  logic [12:0] sm_wide, sm_shift;
  logic        sm_sticky;
  assign sm_wide = {m_s, 2'b00};

  always_comb begin
    if (diff >= 5'd13) begin
      sm_shift  = '0;
      sm_sticky = |sm_wide;
    end else begin
      sm_shift  = sm_wide >> diff;
      sm_sticky = |(sm_wide & ((13'd1 << diff) - 13'd1));
    end
  end

  // 14-bit working format: {hidden, frac[9:0], guard, round, sticky}.
  logic [13:0] ext_l, ext_s, dif;
  logic [14:0] sum;
  logic        eff_sub;
  logic [3:0]  lz;

  assign ext_l   = {m_l, 3'b000};
  assign ext_s   = {sm_shift, sm_sticky};
  assign eff_sub = lg.sign ^ sm.sign;
  assign sum     = {1'b0, ext_l} + {1'b0, ext_s};
  assign dif     = ext_l - ext_s;

  fp16_lzc u_lzc (
    .data  (dif),
    .count (lz)
  );

  // Normalise. Left shifts of more than one place only happen when the
  // exponents differ by at most one, where no bits reached sticky.
  logic [13:0]       norm;
  logic signed [6:0] exp_n;

  always_comb begin
    if (eff_sub) begin
      norm  = dif << lz;
      exp_n = $signed({2'b00, lg.exp}) - $signed({3'b000, lz});
    end else if (sum[14]) begin
      norm  = {sum[14:2], sum[1] | sum[0]};
      exp_n = $signed({2'b00, lg.exp}) + 7'sd1;
    end else begin
      norm  = sum[13:0];
      exp_n = $signed({2'b00, lg.exp});
    end
  end

  // Round to nearest, ties to even; a carry out renormalises.
  logic              rnd_up;
  logic [11:0]       rnd;
  logic signed [6:0] exp_r;
  logic [9:0]        frac_r;

  assign rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign rnd    = {1'b0, norm[13:3]} + {11'd0, rnd_up};
  assign exp_r  = exp_n + $signed({6'd0, rnd[11]});
  assign frac_r = rnd[11] ? rnd[10:1] : rnd[9:0];

  logic [15:0] result;

  always_comb begin
    result = {lg.sign, exp_r[4:0], frac_r};
    if (ca == FP_NAN || cb == FP_NAN) begin
      result = QNAN;
    end else if (ca == FP_INF && cb == FP_INF && fa.sign != fb.sign) begin
      result = QNAN;
    end else if (ca == FP_INF) begin
      result = a;
    end else if (cb == FP_INF) begin
      result = b;
    end else if (ca == FP_ZERO && cb == FP_ZERO) begin
      result = {fa.sign & fb.sign, 15'd0};
    end else if (ca == FP_ZERO) begin
      result = b;
    end else if (cb == FP_ZERO) begin
      result = a;
    end else if (eff_sub && dif == '0) begin
      result = 16'h0000;
    end else if (exp_n <= 7'sd0) begin
      result = {lg.sign, 15'd0};
    end else if (exp_r >= $signed(7'(EXP_MAX))) begin
      result = lg.sign ? NEG_INF : POS_INF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= 16'h0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= result;
    end
  end

endmodule

// File: tb/tb_fp16_adder.sv
module tb_fp16_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] out;

  fp16_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_q[$];
  logic [15:0] hold_val = 16'h0000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // {a, b, expected sum}, hand-computed.
  localparam int NV = 16;
  logic [47:0] vecs [NV] = '{
    {16'h3DCC, 16'hB960, 16'h3A38},  // 1.4492 - 0.671875
    {16'h3C00, 16'h3C00, 16'h4000},  // 1 + 1
    {16'h3C00, 16'hBC00, 16'h0000},  // exact cancellation
    {16'h3C00, 16'h1000, 16'h3C00},  // tie, even lsb stays
    {16'h3C01, 16'h1000, 16'h3C02},  // tie, odd lsb rounds up
    {16'h7BFF, 16'h7BFF, 16'h7C00},  // overflow
    {16'h7C00, 16'hFC00, 16'h7E00},  // +inf + -inf
    {16'h7E01, 16'h3C00, 16'h7E00},  // nan in
    {16'h8000, 16'h8000, 16'h8000},  // -0 + -0
    {16'h0000, 16'hB960, 16'hB960},  // zero passthrough
    {16'h0001, 16'h3C00, 16'h3C00},  // subnormal flushed
    {16'h0400, 16'h8401, 16'h8000},  // underflow to signed zero
    {16'h4000, 16'h3C00, 16'h4200},  // 2 + 1
    {16'hFC00, 16'h3C00, 16'hFC00},  // -inf dominates
    {16'h3C00, 16'hC000, 16'hBC00},  // 1 - 2
    {16'h3C00, 16'h1001, 16'h3C01}   // above half, rounds up
  };

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
    @(negedge clk);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a        = 16'($urandom);
      b        = 16'($urandom);
    end
  endtask

  always @(negedge rst_n) hold_val = 16'h0000;

  // Monitor: compares each presented result against the scoreboard, and
  // checks that out holds while out_valid is low.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got out_valid=1 out=%h, expected no result", out);
        end else begin
          hold_val = exp_q.pop_front();
          check("result", out, hold_val);
        end
      end else begin
        check("hold", out, hold_val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset_out", out, 16'h0000);
    check("reset_valid", {15'd0, out_valid}, 16'h0000);
    rst_n = 1'b1;

    // Back-to-back vectors, then a gapped replay.
    for (int i = 0; i < NV; i++) send(vecs[i][47:32], vecs[i][31:16], vecs[i][15:0]);
    idle(3);
    for (int i = 0; i < NV; i += 3) begin
      send(vecs[i][47:32], vecs[i][31:16], vecs[i][15:0]);
      idle(1 + (i % 2));
    end
    idle(2);

    // Asynchronous reset pulse between edges.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", out, 16'h0000);
    check("async_rst_valid", {15'd0, out_valid}, 16'h0000);
    #1 rst_n = 1'b1;

    // Reset held across a sampling edge discards the operation.
    @(negedge clk);
    a        = 16'h3C00;
    b        = 16'h3C00;
    in_valid = 1'b1;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    check("discard_out", out, 16'h0000);
    check("discard_valid", {15'd0, out_valid}, 16'h0000);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // First result after reset appears one cycle after sampling.
    send(16'h4000, 16'h3C00, 16'h4200);
    @(posedge clk);
    #1;
    check("first_valid", {15'd0, out_valid}, 16'h0001);
    check("first_out", out, 16'h4200);
    idle(2);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
